prio_encoder_rr: RTL and testbench

Registered, parametrised N-to-log2(N) encoder. It accepts a request vector per valid/ready handshake and returns the encoded index of one asserted bit, plus `hit` (any bit set) and `multi` (more than one bit set) flags. Zero and multi-hot inputs resolve deterministically; there is no high-Z output. Selection is fixed-priority (lowest index wins) or round-robin from a rotating pointer, chosen per beat. It is the general-purpose successor to the fixed 4-to-2 encoder, for arbitration and interrupt-index paths.

---
 rtl/prio_encoder_rr.sv | 96 +++++++++
 tb/tb_prio_encoder_rr.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered N-to-log2(N) encoder, fixed or round-robin.
// Ports: clk, rst_n, i[N], rr_en, in_valid/in_ready -> y[W], hit, multi,
//        out_valid/out_ready. One output register, 1-cycle latency.
module prio_encoder_rr #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i,
  input  logic         rr_en,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] y,
  output logic         hit,
  output logic         multi,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [W:0]   NW    = (W+1)'(N);
  localparam logic [W-1:0] LAST  = W'(N-1);
  localparam logic [W-1:0] ONE_W = W'(1);
  localparam logic [N-1:0] ONE_N = N'(1);

  logic [W-1:0] ptr;
  logic [W-1:0] ptr_nxt;
  logic [W-1:0] sel_fix;
  logic [W-1:0] sel_rr;
  logic [W-1:0] sel;
  logic [W:0]   idx;
  logic         hit_c;
  logic         multi_c;
  logic         acc;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  assign hit_c   = |i;
  // Clearing the lowest set bit leaves something iff 2+ bits were set.
  assign multi_c = (i & (i - ONE_N)) != '0;

  // Walk downward so the last overwrite is the lowest index.
  always_comb begin
    sel_fix = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (i[k]) sel_fix = W'(k);
    end
  end

  // Same walk over the rotated order ptr, ptr+1, ... wrapping at N.
  always_comb begin
    sel_rr = '0;
    idx    = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (W+1)'(k);
      if (idx >= NW) idx = idx - NW;
      if (i[idx[W-1:0]]) sel_rr = idx[W-1:0];
    end
  end

  assign sel = rr_en ? sel_rr : sel_fix;

  always_comb begin
    ptr_nxt = ptr;
    if (acc && rr_en && hit_c) begin
      if (sel_rr == LAST) ptr_nxt = '0;
      else                ptr_nxt = sel_rr + ONE_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      hit       <= 1'b0;
      multi     <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      y         <= sel;
      hit       <= hit_c;
      multi     <= multi_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr: bench for prio_encoder_rr at N=4 and N=5.
// Directed table, corner sequences and a randomized reference model.
module tb_prio_encoder_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] i4;
  logic       rr4, iv4, ir4, ov4, ordy4, h4, m4;
  logic [1:0] y4;
  logic [4:0] i5;
  logic       rr5, iv5, ir5, ov5, ordy5, h5, m5;
  logic [2:0] y5;

  int ncmp = 0;
  int nerr = 0;

  prio_encoder_rr #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .i(i4), .rr_en(rr4),
    .in_valid(iv4), .in_ready(ir4), .y(y4), .hit(h4),
    .multi(m4), .out_valid(ov4), .out_ready(ordy4)
  );

  prio_encoder_rr #(.N(5)) u5 (
    .clk(clk), .rst_n(rst_n), .i(i5), .rr_en(rr5),
    .in_valid(iv5), .in_ready(ir5), .y(y5), .hit(h5),
    .multi(m5), .out_valid(ov5), .out_ready(ordy5)
  );

  typedef struct {
    logic [3:0] i;
    bit         rr;
    int         y;
    bit         h;
    bit         m;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Spec-level reference: scan indices start, start+1, ... mod n.
  function automatic void ref_enc(input int n, input logic [7:0] req,
                                  input bit rr, input int p,
                                  output int ry, output bit rh,
                                  output bit rm);
    int start;
    start = rr ? p : 0;
    rh = $countones(req) != 0;
    rm = $countones(req) >= 2;
    ry = 0;
    for (int k = 0; k < n; k++) begin
      if (req[(start + k) % n]) begin
        ry = (start + k) % n;
        break;
      end
    end
  endfunction

  task automatic beat4(input logic [3:0] v, input bit rr, input int ey,
                       input bit eh, input bit em, input string nm);
    i4 = v; rr4 = rr; iv4 = 1'b1; ordy4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
    chk({nm, " out_valid"}, 32'(ov4), 32'(1));
    chk({nm, " y"}, 32'(y4), 32'(ey));
    chk({nm, " hit"}, 32'(h4), 32'(eh));
    chk({nm, " multi"}, 32'(m4), 32'(em));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  bit mov, mh, mm, acc, rnd_iv, rnd_or, rnd_rr;
  int my, mptr, ry;
  bit rh, rm;
  logic [3:0] rnd_i;

  initial begin
    rst_n = 1'b0;
    i4 = '0; rr4 = 1'b0; iv4 = 1'b0; ordy4 = 1'b1;
    i5 = '0; rr5 = 1'b0; iv5 = 1'b0; ordy5 = 1'b1;

    tbl.push_back('{4'b0100, 1'b0, 2, 1'b1, 1'b0});
    tbl.push_back('{4'b0001, 1'b0, 0, 1'b1, 1'b0});
    tbl.push_back('{4'b0010, 1'b0, 1, 1'b1, 1'b0});
    tbl.push_back('{4'b1001, 1'b0, 0, 1'b1, 1'b1});
    tbl.push_back('{4'b1101, 1'b0, 0, 1'b1, 1'b1});
    tbl.push_back('{4'b0000, 1'b0, 0, 1'b0, 1'b0});
    tbl.push_back('{4'b1111, 1'b1, 0, 1'b1, 1'b1});
    tbl.push_back('{4'b1111, 1'b1, 1, 1'b1, 1'b1});
    tbl.push_back('{4'b1111, 1'b1, 2, 1'b1, 1'b1});
    tbl.push_back('{4'b1111, 1'b1, 3, 1'b1, 1'b1});
    tbl.push_back('{4'b1111, 1'b1, 0, 1'b1, 1'b1});
    tbl.push_back('{4'b1010, 1'b1, 1, 1'b1, 1'b1});
    tbl.push_back('{4'b1010, 1'b1, 3, 1'b1, 1'b1});
    tbl.push_back('{4'b1010, 1'b1, 1, 1'b1, 1'b1});
    tbl.push_back('{4'b1010, 1'b1, 3, 1'b1, 1'b1});

    #3;
    chk("reset out_valid", 32'(ov4), 32'(0));
    chk("reset y", 32'(y4), 32'(0));
    chk("reset hit", 32'(h4), 32'(0));
    chk("reset multi", 32'(m4), 32'(0));
    chk("reset in_ready", 32'(ir4), 32'(1));
    chk("reset n5 out_valid", 32'(ov5), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[n]) begin
      beat4(tbl[n].i, tbl[n].rr, tbl[n].y, tbl[n].h, tbl[n].m,
            $sformatf("tbl%0d", n));
    end

    // N=5 round-robin wraps 4 -> 0.
    for (int k = 0; k < 6; k++) begin
      i5 = 5'b11111; rr5 = 1'b1; iv5 = 1'b1; ordy5 = 1'b1;
      #1;
      chk($sformatf("n5 in_ready%0d", k), 32'(ir5), 32'(1));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("n5 y%0d", k), 32'(y5), 32'(k % 5));
      chk($sformatf("n5 valid%0d", k), 32'(ov5), 32'(1));
      chk($sformatf("n5 multi%0d", k), 32'(m5 & h5), 32'(1));
    end
    iv5 = 1'b0;

    // Backpressure: held beat stays stable, then drains.
    i4 = 4'b0100; rr4 = 1'b0; iv4 = 1'b1; ordy4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp first y", 32'(y4), 32'(2));
    i4 = 4'b1000; ordy4 = 1'b0;
    #1;
    chk("bp in_ready", 32'(ir4), 32'(0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp hold valid%0d", k), 32'(ov4), 32'(1));
      chk($sformatf("bp hold y%0d", k), 32'(y4), 32'(2));
      chk($sformatf("bp hold rdy%0d", k), 32'(ir4), 32'(0));
    end
    ordy4 = 1'b1;
    #1;
    chk("bp release ready", 32'(ir4), 32'(1));
    @(posedge clk);
    @(negedge clk);
    chk("bp next valid", 32'(ov4), 32'(1));
    chk("bp next y", 32'(y4), 32'(3));
    iv4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp drained", 32'(ov4), 32'(0));

    // Reset with a pending beat; pending beat also moved ptr to 1.
    i4 = 4'b1111; rr4 = 1'b1; iv4 = 1'b1; ordy4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0; ordy4 = 1'b0;
    chk("pend valid", 32'(ov4), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(ov4), 32'(0));
    chk("arst y", 32'(y4), 32'(0));
    chk("arst hit", 32'(h4), 32'(0));
    chk("arst ready", 32'(ir4), 32'(1));
    rst_n = 1'b1;
    ordy4 = 1'b1;
    beat4(4'b1111, 1'b1, 0, 1'b1, 1'b1, "ptr after rst");

    // Mode mix: fixed beat in the middle leaves ptr alone.
    beat4(4'b1111, 1'b1, 1, 1'b1, 1'b1, "mix rr1");
    beat4(4'b1111, 1'b0, 0, 1'b1, 1'b1, "mix fixed");
    beat4(4'b1111, 1'b1, 2, 1'b1, 1'b1, "mix rr2");
    beat4(4'b0000, 1'b1, 0, 1'b0, 1'b0, "mix zero");
    beat4(4'b1111, 1'b1, 3, 1'b1, 1'b1, "mix rr3");

    // Randomized run against the reference model.
    do_reset();
    mov = 1'b0; my = 0; mh = 1'b0; mm = 1'b0; mptr = 0;
    for (int c = 0; c < 400; c++) begin
      rnd_i  = 4'($urandom_range(0, 15));
      rnd_rr = 1'($urandom_range(0, 1));
      rnd_iv = $urandom_range(0, 3) != 0;
      rnd_or = $urandom_range(0, 3) != 0;
      i4 = rnd_i; rr4 = rnd_rr; iv4 = rnd_iv; ordy4 = rnd_or;
      #1;
      chk("rnd out_valid", 32'(ov4), 32'(mov));
      chk("rnd in_ready", 32'(ir4), 32'(!mov || rnd_or));
      if (mov) begin
        chk("rnd y", 32'(y4), 32'(my));
        chk("rnd hit", 32'(h4), 32'(mh));
        chk("rnd multi", 32'(m4), 32'(mm));
      end
      acc = rnd_iv && (!mov || rnd_or);
      if (acc) begin
        ref_enc(4, {4'b0, rnd_i}, rnd_rr, mptr, ry, rh, rm);
        if (rnd_rr && rh) mptr = (ry + 1) % 4;
        mov = 1'b1; my = ry; mh = rh; mm = rm;
      end else if (rnd_or) begin
        mov = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    iv4 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
